gmii_rx_mac: RTL and testbench

//  Receive MAC for a GMII PHY: strips preamble/SFD, checks length and FCS, emits frame bytes as AXIS.

---
 rtl/gmii_rx_mac.sv | 114 +++++++++++
 tb/tb_gmii_rx_mac.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_mac.sv
// gmii_rx_mac: GMII receive MAC that strips preamble/SFD, checks length and FCS, and streams DA..payload as AXIS
module gmii_rx_mac #(
  parameter int          MIN_FRAME   = 64,
  parameter int          MAX_FRAME   = 1518,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic       clk,
  input  logic       sresetn,
  input  logic [7:0] eth_rxd,
  input  logic       eth_rxdv,
  input  logic       eth_rxer,
  output logic       axis_o_tvalid,
  output logic [7:0] axis_o_tdata,
  output logic       axis_o_tlast,
  output logic       axis_o_tuser,
  output logic       frame_good,
  output logic       frame_bad
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [10:0] MIN_N   = 11'(MIN_FRAME);
  localparam logic [10:0] GIANT_N = 11'(MAX_FRAME - 1);
  localparam logic [10:0] LAG_N   = 11'd5;

  state_t          state;
  logic [4:0][7:0] sr;
  logic [10:0]     n;
  logic [31:0]     crc;
  logic            rxer_seen;
  logic            bad_frame;

  // Ethernet CRC-32 kept in non-reflected form (bits fed LSB first), so a good frame leaves 32'hC704DD7B
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction

  assign bad_frame = rxer_seen | (n < MIN_N) | (crc != CRC_RESIDUE);

  // Frame FSM: four-byte FCS hidden by a five-byte delay line, all outputs registered
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state         <= DROP;
      sr            <= '0;
      n             <= '0;
      crc           <= '1;
      rxer_seen     <= 1'b0;
      axis_o_tvalid <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tlast  <= 1'b0;
      axis_o_tuser  <= 1'b0;
      frame_good    <= 1'b0;
      frame_bad     <= 1'b0;
    end else begin
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tuser  <= 1'b0;
      frame_good    <= 1'b0;
      frame_bad     <= 1'b0;
      case (state)
        IDLE, PRE: begin
          n         <= '0;
          crc       <= '1;
          rxer_seen <= 1'b0;
          if (!eth_rxdv)
            state <= IDLE;
          else if (eth_rxd == 8'hD5)
            state <= DATA;
          else if (eth_rxd == 8'h55)
            state <= PRE;
          else begin
            state     <= DROP;
            frame_bad <= (state == PRE);
          end
        end
        DATA: begin
          if (eth_rxdv) begin
            sr  <= {sr[3:0], eth_rxd};
            n   <= (n == '1) ? n : n + 11'd1;
            crc <= crc32_byte(crc, eth_rxd);
            if (eth_rxer)
              rxer_seen <= 1'b1;
            if (n >= LAG_N) begin
              axis_o_tvalid <= 1'b1;
              axis_o_tdata  <= sr[4];
            end
            // the byte that brings the count to MAX_FRAME ends the frame as a giant
            if (n == GIANT_N) begin
              axis_o_tlast <= 1'b1;
              axis_o_tuser <= 1'b1;
              frame_bad    <= 1'b1;
              state        <= DROP;
            end
          end else begin
            state <= IDLE;
            if (n >= LAG_N) begin
              axis_o_tvalid <= 1'b1;
              axis_o_tdata  <= sr[4];
              axis_o_tlast  <= 1'b1;
              axis_o_tuser  <= bad_frame;
              frame_good    <= !bad_frame;
              frame_bad     <= bad_frame;
            end else
              frame_bad <= 1'b1;
          end
        end
        default: state <= eth_rxdv ? DROP : IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_rx_mac.sv
// tb_gmii_rx_mac: scoreboard bench for the GMII receive MAC
module tb_gmii_rx_mac;
  logic       clk = 1'b0;
  logic       sresetn = 1'b0;
  logic [7:0] eth_rxd = '0;
  logic       eth_rxdv = 1'b0;
  logic       eth_rxer = 1'b0;
  logic       axis_o_tvalid;
  logic [7:0] axis_o_tdata;
  logic       axis_o_tlast;
  logic       axis_o_tuser;
  logic       frame_good;
  logic       frame_bad;

  int errors = 0;
  int checks = 0;
  int good_cnt = 0;
  int bad_cnt = 0;
  int exp_good = 0;
  int exp_bad = 0;
  int stray = 0;
  bit ignore = 1'b0;
  logic [7:0] fr[$];
  logic [9:0] exp_q[$];

  gmii_rx_mac dut (
    .clk(clk), .sresetn(sresetn), .eth_rxd(eth_rxd), .eth_rxdv(eth_rxdv), .eth_rxer(eth_rxer),
    .axis_o_tvalid(axis_o_tvalid), .axis_o_tdata(axis_o_tdata), .axis_o_tlast(axis_o_tlast),
    .axis_o_tuser(axis_o_tuser), .frame_good(frame_good), .frame_bad(frame_bad)
  );

  always #4 clk = ~clk;

  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < len; i++) begin
      c ^= {24'h0, fr[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int p, input int mul, input int off);
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < p; i++)
      fr.push_back(8'(i * mul + off));
    f = fcs_of(p);
    for (int i = 0; i < 4; i++)
      fr.push_back(f[8*i +: 8]);
  endtask

  task automatic push_exp(input int cnt, input bit user);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({fr[i], i == cnt - 1, (i == cnt - 1) & user});
  endtask

  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    if (frame_good) good_cnt++;
    if (frame_bad) bad_cnt++;
    if (axis_o_tvalid && ignore)
      stray++;
    else if (axis_o_tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected byte %h last=%b user=%b, required no output", axis_o_tdata, axis_o_tlast, axis_o_tuser);
      end else begin
        e = exp_q.pop_front();
        if ({axis_o_tdata, axis_o_tlast, axis_o_tuser} !== e) begin
          errors++;
          $display("FAIL beat: data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   axis_o_tdata, axis_o_tlast, axis_o_tuser, e[9:2], e[1], e[0]);
        end
      end
    end
    if (frame_good && !(axis_o_tvalid && axis_o_tlast && !axis_o_tuser)) begin
      checks++;
      errors++;
      $display("FAIL good_pulse: frame_good=1 with tvalid=%b tlast=%b tuser=%b, required tlast with tuser=0",
               axis_o_tvalid, axis_o_tlast, axis_o_tuser);
    end
  endtask

  task automatic drive_frame(input int pre, input int rxer_idx, input int gap);
    for (int i = 0; i < pre; i++) begin
      tick(); eth_rxdv = 1'b1; eth_rxd = 8'h55; eth_rxer = 1'b0;
    end
    tick(); eth_rxdv = 1'b1; eth_rxd = 8'hD5;
    for (int i = 0; i < fr.size(); i++) begin
      tick(); eth_rxd = fr[i]; eth_rxer = (i == rxer_idx);
    end
    for (int g = 0; g < gap; g++) begin
      tick(); eth_rxdv = 1'b0; eth_rxd = 8'h00; eth_rxer = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick(); k++;
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: %0d bytes still missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (good_cnt != exp_good) begin
      errors++;
      $display("FAIL %s_good: frame_good pulses=%0d, required %0d", name, good_cnt, exp_good);
      good_cnt = exp_good;
    end
    checks++;
    if (bad_cnt != exp_bad) begin
      errors++;
      $display("FAIL %s_bad: frame_bad pulses=%0d, required %0d", name, bad_cnt, exp_bad);
      bad_cnt = exp_bad;
    end
  endtask

  task automatic test_reset();
    repeat (4) tick();
    checks++;
    if ({axis_o_tvalid, axis_o_tdata, axis_o_tlast, axis_o_tuser, frame_good, frame_bad} !== 13'h0) begin
      errors++;
      $display("FAIL reset: outputs=%h, required 0",
               {axis_o_tvalid, axis_o_tdata, axis_o_tlast, axis_o_tuser, frame_good, frame_bad});
    end
    sresetn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_good();
    build(60, 1, 0); push_exp(60, 1'b0); exp_good++;
    drive_frame(7, -1, 12);
    drain("good");
  endtask

  task automatic test_bad_fcs();
    build(60, 1, 0); fr[62] = ~fr[62]; push_exp(60, 1'b1); exp_bad++;
    drive_frame(7, -1, 12);
    drain("bad_fcs");
  endtask

  task automatic test_runt();
    build(46, 3, 5); push_exp(46, 1'b1); exp_bad++;
    drive_frame(7, -1, 12);
    drain("runt");
  endtask

  task automatic test_rxer();
    build(60, 5, 1); push_exp(60, 1'b1); exp_bad++;
    drive_frame(7, 10, 12);
    drain("rxer");
  endtask

  task automatic test_giant();
    fr.delete();
    for (int i = 0; i < 1600; i++) fr.push_back(8'(i * 7 + 3));
    push_exp(1513, 1'b1); exp_bad++;
    drive_frame(7, -1, 12);
    drain("giant");
    build(64, 1, 9); push_exp(64, 1'b0); exp_good++;
    drive_frame(7, -1, 12);
    drain("after_giant");
  endtask

  task automatic test_tiny();
    fr.delete();
    fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
    exp_bad++;
    drive_frame(1, -1, 12);
    drain("tiny");
  endtask

  task automatic test_bad_preamble();
    tick(); eth_rxdv = 1'b1; eth_rxd = 8'h55;
    tick(); eth_rxd = 8'h55;
    tick(); eth_rxd = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      tick(); eth_rxd = 8'(i);
    end
    tick(); eth_rxdv = 1'b0;
    exp_bad++;
    drain("bad_preamble");
  endtask

  task automatic test_back_to_back();
    build(60, 2, 0); push_exp(60, 1'b0); exp_good++;
    drive_frame(7, -1, 1);
    build(70, 1, 100); push_exp(70, 1'b0); exp_good++;
    drive_frame(7, -1, 12);
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    build(60, 1, 40);
    ignore = 1'b1;
    tick(); eth_rxdv = 1'b1; eth_rxd = 8'hD5;
    for (int i = 0; i < 20; i++) begin
      tick(); eth_rxd = fr[i];
    end
    tick(); eth_rxd = fr[20]; sresetn = 1'b0;
    tick(); eth_rxd = fr[21]; sresetn = 1'b1;
    checks++;
    if ({axis_o_tvalid, axis_o_tlast, axis_o_tuser, frame_good, frame_bad} !== 5'h0) begin
      errors++;
      $display("FAIL mid_reset_out: tvalid/tlast/tuser/good/bad=%b, required 00000",
               {axis_o_tvalid, axis_o_tlast, axis_o_tuser, frame_good, frame_bad});
    end
    stray = 0;
    for (int i = 22; i < fr.size(); i++) begin
      tick(); eth_rxd = fr[i];
    end
    tick(); eth_rxdv = 1'b0;
    repeat (8) tick();
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_reset_stray: %0d bytes emitted after reset, required 0", stray);
    end
    ignore = 1'b0;
    drain("mid_reset_pulses");
    build(60, 1, 0); push_exp(60, 1'b0); exp_good++;
    drive_frame(7, -1, 12);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_fcs();
    test_runt();
    test_rxer();
    test_giant();
    test_tiny();
    test_bad_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
